adder_measure_ctrl: RTL and testbench

ADDER_MEASURE_CTRL -- requirements
Module: adder_measure_ctrl

---
 rtl/adder_measure_ctrl.sv | 174 +++++++++++++++++
 tb/tb_adder_measure_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adder_measure_ctrl.sv
// Measurement sequencer for a ring oscillator that runs through an adder under test.
// It latches the operands, lets the adder settle, runs the ring, counts its edges, then reports the sum.
module adder_measure_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DRAIN_CYCLES  = 3
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [15:0] window_len,
  input  logic        use_bypass,
  input  logic        ring_in,
  input  logic [31:0] sum_in,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  output logic        ring_en,
  output logic        bypass_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] edge_count,
  output logic [31:0] sum_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [15:0] win_q, win_d;
  logic        byp_q, byp_d;
  logic [31:0] edge_count_q, edge_count_d;
  logic [31:0] sum_out_q, sum_out_d;
  logic        ring_s1_q, ring_s1_d;
  logic        ring_s2_q, ring_s2_d;
  logic        ring_dly_q, ring_dly_d;
  logic        start_ok;
  logic        ring_rise;

  // Abort outranks start, so a simultaneous request never launches a measurement.
  assign start_ok  = (state_q == IDLE) && start && !abort;
  assign ring_rise = ring_s2_q && !ring_dly_q;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      win_q        <= '0;
      byp_q        <= 1'b0;
      edge_count_q <= '0;
      sum_out_q    <= '0;
      ring_s1_q    <= 1'b0;
      ring_s2_q    <= 1'b0;
      ring_dly_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      win_q        <= win_d;
      byp_q        <= byp_d;
      edge_count_q <= edge_count_d;
      sum_out_q    <= sum_out_d;
      ring_s1_q    <= ring_s1_d;
      ring_s2_q    <= ring_s2_d;
      ring_dly_q   <= ring_dly_d;
    end
  end

  // The phase counter is loaded with (length - 1) on entry and only decrements while nonzero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = LOAD;
          cnt_d   = SETTLE_LAST;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LAST;
        end else if (cnt_q == 16'd0) begin
          if (win_q == 16'd0) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LAST;
          end else begin
            state_d = RUN;
            cnt_d   = win_q - 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RUN: begin
        if (abort || (cnt_q == 16'd0)) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LAST;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == 16'd0) begin
          state_d = REPORT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      REPORT: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_comb begin
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    win_d        = win_q;
    byp_d        = byp_q;
    edge_count_d = edge_count_q;
    sum_out_d    = sum_out_q;
    ring_s1_d    = ring_in;
    ring_s2_d    = ring_s1_q;
    ring_dly_d   = ring_s2_q;
    if (start_ok) begin
      op_a_d       = op_a;
      op_b_d       = op_b;
      win_d        = window_len;
      byp_d        = use_bypass;
      edge_count_d = '0;
    end else if (((state_q == RUN) || (state_q == DRAIN)) && ring_rise &&
                 (edge_count_q != 32'hFFFF_FFFF)) begin
      edge_count_d = edge_count_q + 32'd1;
    end
    // Capture on entry so sum_out is already valid during the done pulse.
    if ((state_d == REPORT) && (state_q != REPORT)) begin
      sum_out_d = sum_in;
    end
  end

  always_comb begin
    ring_en    = (state_q == RUN);
    busy       = (state_q != IDLE);
    done       = (state_q == REPORT);
    adder_a    = op_a_q;
    adder_b    = op_b_q;
    bypass_sel = byp_q;
    edge_count = edge_count_q;
    sum_out    = sum_out_q;
  end

endmodule

// File: tb/tb_adder_measure_ctrl.sv
// Directed bench for adder_measure_ctrl with an ideal adder on sum_in and a gated ring stimulus.
module tb_adder_measure_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, use_bypass, ring_in;
  logic [31:0] op_a, op_b, sum_in;
  logic [15:0] window_len;
  logic [31:0] adder_a, adder_b, edge_count, sum_out;
  logic        ring_en, bypass_sel, busy, done;

  int n_tot  = 0;
  int n_pass = 0;
  int cyc, bc, dc, dcyc, re_seen;
  bit ring_on;
  logic [31:0] ec_snap;

  adder_measure_ctrl #(.SETTLE_CYCLES(2), .DRAIN_CYCLES(3)) dut (
    .wb_clk_i   (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .op_a       (op_a),
    .op_b       (op_b),
    .window_len (window_len),
    .use_bypass (use_bypass),
    .ring_in    (ring_in),
    .sum_in     (sum_in),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .ring_en    (ring_en),
    .bypass_sel (bypass_sel),
    .busy       (busy),
    .done       (done),
    .edge_count (edge_count),
    .sum_out    (sum_out)
  );

  always #5 clk = ~clk;

  assign sum_in = adder_a + adder_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One cycle: sample outputs at the falling edge, then retire one-cycle pulses and move the ring.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (busy) bc++;
    if (done) begin
      dc++;
      dcyc = cyc;
    end
    if (ring_en) re_seen = 1;
    start   = 1'b0;
    abort   = 1'b0;
    ring_in = ring_on ? ((cyc % 4) >= 2) : 1'b0;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [15:0] w);
    cyc = 0; bc = 0; dc = 0; dcyc = -1; re_seen = 0;
    op_a = a; op_b = b; window_len = w; start = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; use_bypass = 1'b0; ring_in = 1'b0;
    op_a = '0; op_b = '0; window_len = '0; ring_on = 1'b0; cyc = 0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ring_en", {31'd0, ring_en}, 32'd0);
    chk("rst_edge_count", edge_count, 32'd0);
    chk("rst_sum_out", sum_out, 32'd0);
    chk("rst_adder_a", adder_a, 32'd0);
    chk("rst_sync", {29'd0, dut.ring_s1_q, dut.ring_s2_q, dut.ring_dly_q}, 32'd0);
    step(); step();

    // Nominal run straight out of reset: 5+7, window 10, ring rising every 4 cycles
    rst_n = 1'b1; ring_on = 1'b1; use_bypass = 1'b1;
    launch(32'd5, 32'd7, 16'd10);
    step();
    chk("first_edge_start", {31'd0, busy}, 32'd1);
    chk("load_adder_a", adder_a, 32'd5);
    chk("load_adder_b", adder_b, 32'd7);
    chk("load_bypass", {31'd0, bypass_sel}, 32'd1);
    repeat (21) step();
    chk("t1_busy_cycles", bc, 32'd16);
    chk("t1_done_count", dc, 32'd1);
    chk("t1_done_cycle", dcyc, 32'd16);
    chk("t1_sum_out", sum_out, 32'd12);
    chk("t1_edge_range", {31'd0, (edge_count >= 32'd3) && (edge_count <= 32'd4)}, 32'd1);
    ec_snap = edge_count;
    repeat (6) step();
    chk("t1_edge_hold", edge_count, ec_snap);

    // Zero-length window with a quiet ring
    ring_on = 1'b0; use_bypass = 1'b0;
    repeat (4) step();
    launch(32'd3, 32'd4, 16'd0);
    repeat (10) step();
    chk("t2_ring_en_seen", re_seen, 32'd0);
    chk("t2_done_cycle", dcyc, 32'd6);
    chk("t2_edge_count", edge_count, 32'd0);
    chk("t2_sum_out", sum_out, 32'd7);

    // Abort on the third RUN cycle of a long window
    ring_on = 1'b1;
    launch(32'd1, 32'd2, 16'd100);
    repeat (5) step();
    chk("t3_run_ring_en", {31'd0, ring_en}, 32'd1);
    abort = 1'b1;
    step();
    chk("t3_abort_ring_en", {31'd0, ring_en}, 32'd0);
    repeat (8) step();
    chk("t3_done_cycle", dcyc, 32'd9);
    chk("t3_done_count", dc, 32'd1);
    chk("t3_idle_busy", {31'd0, busy}, 32'd0);

    // Abort beats a simultaneous start in IDLE
    start = 1'b1; abort = 1'b1; op_a = 32'd50;
    step();
    chk("t3_abort_wins", {31'd0, busy}, 32'd0);

    // A second start during RUN is ignored
    launch(32'd9, 32'd10, 16'd20);
    repeat (5) step();
    start = 1'b1; op_a = 32'd99; op_b = 32'd98; window_len = 16'd1;
    step();
    chk("t4_adder_a_held", adder_a, 32'd9);
    chk("t4_adder_b_held", adder_b, 32'd10);
    chk("t4_still_run", {31'd0, ring_en}, 32'd1);
    repeat (25) step();
    chk("t4_done_cycle", dcyc, 32'd26);
    chk("t4_done_count", dc, 32'd1);
    chk("t4_sum_out", sum_out, 32'd19);

    // Saturation from a preloaded count
    launch(32'd0, 32'd0, 16'd40);
    repeat (5) step();
    force dut.edge_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.edge_count_q;
    repeat (45) step();
    chk("t5_saturate", edge_count, 32'hFFFF_FFFF);
    chk("t5_done_count", dc, 32'd1);

    // Asynchronous reset in the middle of RUN
    launch(32'd4, 32'd4, 16'd50);
    repeat (8) step();
    chk("t6_pre_ring_en", {31'd0, ring_en}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ring_en", {31'd0, ring_en}, 32'd0);
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_edge_count", edge_count, 32'd0);
    chk("t6_async_state", {29'd0, dut.state_q}, 32'd0);
    step();
    rst_n = 1'b1;
    launch(32'd6, 32'd6, 16'd2);
    step();
    chk("t6_restart_busy", {31'd0, busy}, 32'd1);
    repeat (12) step();
    chk("t6_restart_sum", sum_out, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
